cp0_ctrl: RTL and testbench
===========================

Name: cp0_ctrl

Overview:
- Parametrised successor of the CP0 register file: holds Count(9), Compare(11), Status(12), Cause(13), EPC(14) and PRId(15).
- Adds hardware/software/timer interrupt detection, exception entry with EPC/Cause capture, and ERET return.
- Sits beside the datapath's MFC0/MTC0 path.
- Supplies the exception vector to PC-select logic and an interrupt request to the pipeline controller.

Parameters:
- NUM_HWINT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+NUM_HWINT-1:2].
- STATUS_RST, 32'h3000_0000, Status reset value.
- EPC_RST, 32'h0000_3000, EPC reset value.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address.
- PRID_VAL, 32'h0001_8000, read-only PRId value.
- TIMER_EN, 1, 1 = Count runs and timer interrupt enabled; 0 = Count frozen, TI never sets.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regNum  in  5  CP0 register number for read and write.
- sel  in  3  select field; only sel==0 is implemented.
- din  in  32  MTC0 write data.
- wEn  in  1  MTC0 write strobe.
- dout  out  32  MFC0 read data (combinational).
- hw_int  in  NUM_HWINT  external interrupt lines, level-sensitive.
- exc_req  in  1  pipeline commits an exception or interrupt this cycle.
- exc_code  in  5  ExcCode for exc_req (0 = Int).
- exc_pc  in  32  faulting/interrupted instruction PC.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  ERET committed this cycle.
- irq  out  1  interrupt pending and allowed.
- exc_vector  out  32  constant EXC_VECTOR.
- epc_out  out  32  current EPC, used as the ERET target.
- in_handler  out  1  equals Status.EXL.

Behaviour:
- Reset (async, rst_n=0):
  - Status=STATUS_RST; Cause=0; EPC=EPC_RST; Count=0; Compare=32'hFFFF_FFFF; count phase bit=0.
  - Outputs follow from these values: irq=0, in_handler=STATUS_RST[1].
  - Reset mid-operation aborts everything immediately.
- Read:
  - dout is combinational from {regNum, sel}.
  - sel!=0, or an unimplemented register number, reads 32'h0.
  - PRId reads PRID_VAL.
- Writable fields via MTC0 (wEn=1, sel==0); all other bits are read-only and unaffected:
  - Status: bits 31:28, 15:8 (IM), 1 (EXL), 0 (IE).
  - Cause: bits 9:8 (software IP) only.
  - EPC: all 32 bits.
  - Count: all 32 bits.
  - Compare: all 32 bits; any write to Compare also clears Cause.TI.
  - Writes to PRId or unimplemented registers are ignored.
- Hardware interrupt sampling: each cycle, Cause.IP[2+k] <= hw_int[k] (one-cycle latency). Unused IP bits read 0.
- Timer:
  - TI drives IP[7], ORed with hw_int[5] if present.
  - With TIMER_EN=1, Count increments every second clk (phase bit toggles each cycle) and wraps 32'hFFFF_FFFF -> 0.
  - When the Count value after update equals Compare, Cause.TI <= 1 (sticky until a Compare write or reset).
  - MTC0 to Count overrides the increment that cycle.
- irq = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]). Combinational from registered state.
- Exception entry (exc_req=1), on the next edge:
  - If EXL was 0: EPC <= exc_bd ? exc_pc-4 : exc_pc, and Cause.BD <= exc_bd.
  - If EXL was already 1: EPC and BD are unchanged (nested exception).
  - Always: Cause.ExcCode[6:2] <= exc_code; Status.EXL <= 1.
- ERET (eret=1): Status.EXL <= 0 on the next edge. epc_out is valid in the same cycle for PC redirect.
- State machine on EXL:
  - NORMAL (EXL=0) -> HANDLER on exc_req.
  - HANDLER -> NORMAL on eret, or on MTC0 clearing EXL.
- Simultaneous events, priority per field:
  - exc_req beats eret, which beats MTC0.
  - exc_req with eret: the exception is taken and EXL stays 1.
  - exc_req with MTC0 to EPC/Cause/Status: the exception update wins for EXL, EPC, BD and ExcCode; other written bits still update.
  - Timer match with a Compare write in the same cycle: TI is cleared.
  - hw_int sampling always occurs.
- All arithmetic is 32-bit unsigned with wrap. exc_pc-4 wraps modulo 2^32.

Test Plan:
- Reset with rst_n low mid-cycle -> dout(12)=32'h3000_0000, dout(14)=32'h0000_3000, dout(13)=0, irq=0, asynchronously.
- MTC0 Status=32'h0000_0401, then hw_int[0]=1 -> Cause.IP[2]=1 after 1 cycle, irq=1; then exc_req, exc_code=0, exc_pc=32'h0000_3010, exc_bd=0 -> EPC=32'h0000_3010, EXL=1, irq=0, in_handler=1.
- exc_req with exc_bd=1, exc_pc=32'h0000_3024, exc_code=8 -> EPC=32'h0000_3020, Cause.BD=1, ExcCode=8; then a second exc_req with exc_pc=32'h0000_4000 -> EPC stays 32'h0000_3020, ExcCode updates.
- Timer: Compare=10, Count=0, IM7=IE=1 -> TI=1 and irq=1 exactly when Count reaches 10 (20 cycles); MTC0 Compare=100 -> TI=0 next cycle.
- exc_req and eret in the same cycle while EXL=1 -> EXL remains 1; eret alone -> EXL=0 next edge, with epc_out equal to EPC during the eret cycle.
- Read regNum=12 with sel=1, and read regNum=3 -> dout=0; MTC0 to PRId -> dout(15) stays PRID_VAL.

Source files
------------

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 control block. It holds Count, Compare, Status,
// Cause, EPC and PRId, detects hardware, software and timer interrupts, and
// handles exception entry (EPC/Cause capture) and ERET return.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   regNum, sel      CP0 register address for MFC0 reads and MTC0 writes
//   din, wEn         MTC0 write data and write strobe
//   dout             MFC0 read data (combinational)
//   hw_int           external interrupt lines, level-sensitive
//   exc_req          exception/interrupt committed this cycle
//   exc_code         ExcCode recorded for exc_req
//   exc_pc, exc_bd   PC of the faulting instruction, branch-delay-slot flag
//   eret             ERET committed this cycle
//   irq              interrupt pending and allowed
//   exc_vector       exception entry address
//   epc_out          current EPC (ERET target)
//   in_handler       Status.EXL
//
// State machine on Status.EXL:
//   state      | meaning
//   ST_NORMAL  | EXL=0, interrupts may be taken, exceptions capture EPC/BD
//   ST_HANDLER | EXL=1, interrupts masked, nested exceptions keep EPC/BD
module cp0_ctrl #(
  parameter int unsigned NUM_HWINT  = 6,
  parameter logic [31:0] STATUS_RST = 32'h3000_0000,
  parameter logic [31:0] EPC_RST    = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           regNum,
  input  logic [2:0]           sel,
  input  logic [31:0]          din,
  input  logic                 wEn,
  output logic [31:0]          dout,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic                 eret,
  output logic                 irq,
  output logic [31:0]          exc_vector,
  output logic [31:0]          epc_out,
  output logic                 in_handler
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  status_hi_q, status_hi_d;
  logic [7:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [5:0]  hw_ip_q, hw_ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;

  logic        wr;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [5:0]  hw_pad;
  logic [7:0]  ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  always_comb begin
    wr         = wEn && (sel == 3'd0);
    wr_count   = wr && (regNum == REG_COUNT);
    wr_compare = wr && (regNum == REG_COMPARE);
    wr_status  = wr && (regNum == REG_STATUS);
    wr_cause   = wr && (regNum == REG_CAUSE);
    wr_epc     = wr && (regNum == REG_EPC);

    hw_pad                  = '0;
    hw_pad[NUM_HWINT-1:0]   = hw_int;

    // IP[7] is shared between the timer and the sixth hardware line
    ip        = {hw_ip_q[5] | ti_q, hw_ip_q[4:0], sw_ip_q};
    status_rd = {status_hi_q, STATUS_RST[27:16], im_q, STATUS_RST[7:2],
                 state_q == ST_HANDLER, ie_q};
    cause_rd  = {bd_q, ti_q, 14'd0, ip, 1'b0, exc_code_q, 2'b00};

    irq        = ie_q && (state_q == ST_NORMAL) && ((ip & im_q) != 8'd0);
    exc_vector = EXC_VECTOR;
    epc_out    = epc_q;
    in_handler = (state_q == ST_HANDLER);

    dout = '0;
    if (sel == 3'd0) begin
      case (regNum)
        REG_COUNT:   dout = count_q;
        REG_COMPARE: dout = compare_q;
        REG_STATUS:  dout = status_rd;
        REG_CAUSE:   dout = cause_rd;
        REG_EPC:     dout = epc_q;
        REG_PRID:    dout = PRID_VAL;
        default:     dout = '0;
      endcase
    end
  end

  always_comb begin
    hw_ip_d = hw_pad;

    // Timer: Count advances on every other edge; an MTC0 to Count wins.
    phase_d = phase_q;
    count_d = count_q;
    if (TIMER_EN) begin
      phase_d = ~phase_q;
      if (phase_q) count_d = count_q + 32'd1;
    end
    if (wr_count) count_d = din;

    compare_d = wr_compare ? din : compare_q;

    ti_d = ti_q;
    if (TIMER_EN && (count_d == compare_q)) ti_d = 1'b1;
    if (wr_compare) ti_d = 1'b0;

    status_hi_d = wr_status ? din[31:28] : status_hi_q;
    im_d        = wr_status ? din[15:8]  : im_q;
    ie_d        = wr_status ? din[0]     : ie_q;
    sw_ip_d     = wr_cause  ? din[9:8]   : sw_ip_q;
    epc_d       = wr_epc    ? din        : epc_q;
    bd_d        = bd_q;
    exc_code_d  = exc_code_q;

    // EXL priority: exception entry, then ERET, then MTC0
    state_d = state_q;
    if (wr_status) state_d = din[1] ? ST_HANDLER : ST_NORMAL;
    if (eret)      state_d = ST_NORMAL;
    if (exc_req) begin
      state_d    = ST_HANDLER;
      exc_code_d = exc_code;
      // A nested exception keeps the original return address
      if (state_q == ST_NORMAL) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= state_e'(STATUS_RST[1]);
      status_hi_q <= STATUS_RST[31:28];
      im_q        <= STATUS_RST[15:8];
      ie_q        <= STATUS_RST[0];
      bd_q        <= 1'b0;
      ti_q        <= 1'b0;
      sw_ip_q     <= '0;
      hw_ip_q     <= '0;
      exc_code_q  <= '0;
      epc_q       <= EPC_RST;
      count_q     <= '0;
      compare_q   <= 32'hFFFF_FFFF;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_hi_q <= status_hi_d;
      im_q        <= im_d;
      ie_q        <= ie_d;
      bd_q        <= bd_d;
      ti_q        <= ti_d;
      sw_ip_q     <= sw_ip_d;
      hw_ip_q     <= hw_ip_d;
      exc_code_q  <= exc_code_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Testbench for cp0_ctrl: directed scenarios plus a randomized run checked
// against a behavioural model of the CP0 registers.
module tb_cp0_ctrl;

  localparam logic [31:0] STATUS_RST = 32'h3000_0000;
  localparam logic [31:0] EPC_RST    = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL   = 32'h0001_8000;
  localparam logic [31:0] WMASK      = 32'hF000_FF03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  regNum;
  logic [2:0]  sel;
  logic [31:0] din;
  logic        wEn;
  logic [31:0] dout;
  logic [5:0]  hw_int;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        irq;
  logic [31:0] exc_vector;
  logic [31:0] epc_out;
  logic        in_handler;

  int checks = 0;
  int errors = 0;
  int unsigned edge_cnt;

  logic [4:0] reg_pool [8] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};

  cp0_ctrl #(
    .NUM_HWINT(6), .STATUS_RST(STATUS_RST), .EPC_RST(EPC_RST),
    .EXC_VECTOR(EXC_VECTOR), .PRID_VAL(PRID_VAL), .TIMER_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .regNum(regNum), .sel(sel), .din(din),
    .wEn(wEn), .dout(dout), .hw_int(hw_int), .exc_req(exc_req),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
    .irq(irq), .exc_vector(exc_vector), .epc_out(epc_out),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; Count advances on the even-numbered ones
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic idle_inputs();
    regNum = 5'd0; sel = 3'd0; din = 32'd0; wEn = 1'b0; hw_int = 6'd0;
    exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0; eret = 1'b0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input logic [2:0] s, output logic [31:0] v);
    regNum = r; sel = s; wEn = 1'b0;
    #1;
    v = dout;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    regNum = r; sel = 3'd0; din = d; wEn = 1'b1;
    clk_step();
    wEn = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    mtc0(5'd12, 32'h0000_FF03);
    mtc0(5'd14, 32'h1234_5678);
    hw_int = 6'h3F;
    clk_step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h3000_0000) begin errors++; $display("FAIL reset_status got %h exp %h", v, 32'h3000_0000); end
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h0000_3000) begin errors++; $display("FAIL reset_epc got %h exp %h", v, 32'h0000_3000); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", v); end
    rd(5'd9, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_count got %h exp 0", v); end
    rd(5'd11, 3'd0, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h exp ffffffff", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (in_handler !== STATUS_RST[1]) begin errors++; $display("FAIL reset_in_handler got %b exp %b", in_handler, STATUS_RST[1]); end
    hw_int = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hwint_exc();
    logic [31:0] v;
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL hw_status_write got %h exp 00000401", v); end
    hw_int = 6'd1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL hw_irq_latency got %b exp 0", irq); end
    clk_step();
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL hw_cause_ip2 got %h exp 00000400", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL hw_irq got %b exp 1", irq); end
    exc_req = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_3010; exc_bd = 1'b0;
    clk_step();
    exc_req = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h0000_3010) begin errors++; $display("FAIL int_epc got %h exp 00003010", v); end
    checks++; if (epc_out !== 32'h0000_3010) begin errors++; $display("FAIL int_epc_out got %h exp 00003010", epc_out); end
    rd(5'd12, 3'd0, v);
    checks++; if (v !== 32'h0000_0403) begin errors++; $display("FAIL int_status got %h exp 00000403", v); end
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL int_in_handler got %b exp 1", in_handler); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_irq_masked got %b exp 0", irq); end
    hw_int = 6'd0;
  endtask

  task automatic test_nested_bd();
    logic [31:0] v;
    do_reset();
    exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_3024; exc_bd = 1'b1;
    clk_step();
    exc_req = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h0000_3020) begin errors++; $display("FAIL bd_epc got %h exp 00003020", v); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h8000_0020) begin errors++; $display("FAIL bd_cause got %h exp 80000020", v); end
    exc_req = 1'b1; exc_code = 5'd5; exc_pc = 32'h0000_4000; exc_bd = 1'b0;
    clk_step();
    exc_req = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h0000_3020) begin errors++; $display("FAIL nested_epc got %h exp 00003020", v); end
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h8000_0014) begin errors++; $display("FAIL nested_cause got %h exp 80000014", v); end
    eret = 1'b1;
    clk_step();
    eret = 1'b0;
    exc_req = 1'b1; exc_code = 5'd0; exc_pc = 32'h0000_0000; exc_bd = 1'b1;
    clk_step();
    exc_req = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap got %h exp fffffffc", v); end
  endtask

  task automatic test_timer();
    logic [31:0] v, c;
    int unsigned n0, exp_cnt;
    int first_k, exp_first;
    do_reset();
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    clk_step();
    mtc0(5'd9, 32'd0);
    n0 = edge_cnt;
    rd(5'd9, 3'd0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL timer_count_write got %0d exp 0", v); end
    first_k = 0;
    for (int k = 1; k <= 24; k++) begin
      clk_step();
      exp_cnt = (n0 + k) / 2 - n0 / 2;
      rd(5'd9, 3'd0, v);
      rd(5'd13, 3'd0, c);
      checks++; if (v !== exp_cnt) begin errors++; $display("FAIL timer_count k=%0d got %0d exp %0d", k, v, exp_cnt); end
      checks++; if (c[30] !== (exp_cnt >= 10)) begin errors++; $display("FAIL timer_ti k=%0d got %b exp %b", k, c[30], exp_cnt >= 10); end
      checks++; if (irq !== (exp_cnt >= 10)) begin errors++; $display("FAIL timer_irq k=%0d got %b exp %b", k, irq, exp_cnt >= 10); end
      if (c[30] && first_k == 0) first_k = k;
    end
    exp_first = (n0 % 2 == 0) ? 20 : 19;
    checks++; if (first_k != exp_first) begin errors++; $display("FAIL timer_latency got %0d exp %0d", first_k, exp_first); end
    mtc0(5'd11, 32'd100);
    rd(5'd13, 3'd0, c);
    checks++; if (c[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear got %b exp 0", c[30]); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL timer_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_eret();
    logic [31:0] v;
    do_reset();
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0000_3100; exc_bd = 1'b0;
    clk_step();
    exc_pc = 32'h0000_5000; eret = 1'b1;
    clk_step();
    exc_req = 1'b0; eret = 1'b0;
    checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL exc_eret_exl got %b exp 1", in_handler); end
    rd(5'd14, 3'd0, v);
    checks++; if (v !== 32'h0000_3100) begin errors++; $display("FAIL exc_eret_epc got %h exp 00003100", v); end
    eret = 1'b1;
    #1;
    checks++; if (epc_out !== 32'h0000_3100) begin errors++; $display("FAIL eret_target got %h exp 00003100", epc_out); end
    clk_step();
    eret = 1'b0;
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL eret_exl got %b exp 0", in_handler); end
    exc_req = 1'b1;
    clk_step();
    exc_req = 1'b0;
    mtc0(5'd12, 32'h0000_0001);
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL mtc0_exl_clear got %b exp 0", in_handler); end
    exc_req = 1'b1;
    clk_step();
    exc_req = 1'b0;
    regNum = 5'd12; sel = 3'd0; din = 32'h0000_0002; wEn = 1'b1; eret = 1'b1;
    clk_step();
    wEn = 1'b0; eret = 1'b0;
    checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL eret_beats_mtc0 got %b exp 0", in_handler); end
  endtask

  task automatic test_reads();
    logic [31:0] v;
    do_reset();
    rd(5'd12, 3'd1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_sel1 got %h exp 0", v); end
    rd(5'd3, 3'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_unimpl got %h exp 0", v); end
    mtc0(5'd15, 32'hDEAD_BEEF);
    rd(5'd15, 3'd0, v);
    checks++; if (v !== PRID_VAL) begin errors++; $display("FAIL prid_ro got %h exp %h", v, PRID_VAL); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 3'd0, v);
    checks++; if (v !== 32'h0000_0300) begin errors++; $display("FAIL cause_mask got %h exp 00000300", v); end
    regNum = 5'd14; sel = 3'd1; din = 32'h1111_2222; wEn = 1'b1;
    clk_step();
    wEn = 1'b0;
    rd(5'd14, 3'd0, v);
    checks++; if (v !== EPC_RST) begin errors++; $display("FAIL sel1_write got %h exp %h", v, EPC_RST); end
    checks++; if (exc_vector !== EXC_VECTOR) begin errors++; $display("FAIL exc_vector got %h exp %h", exc_vector, EXC_VECTOR); end
  endtask

  task automatic test_random();
    logic [31:0] m_status, m_epc, m_count, m_compare, v;
    logic        m_bd, m_ti, m_phase, wr;
    logic [1:0]  m_swip;
    logic [5:0]  m_hwip;
    logic [4:0]  m_exc, r;
    logic [7:0]  m_ip;
    logic [31:0] n_count;
    logic        old_exl;
    do_reset();
    m_status = STATUS_RST; m_epc = EPC_RST; m_count = 0; m_compare = 32'hFFFF_FFFF;
    m_bd = 0; m_ti = 0; m_phase = 0; m_swip = 0; m_hwip = 0; m_exc = 0;
    for (int i = 0; i < 300; i++) begin
      r = reg_pool[$urandom_range(0, 7)];
      regNum = r;
      sel = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      din = (r == 5'd9 || r == 5'd11) ? 32'($urandom_range(0, 30)) : $urandom;
      wEn = ($urandom_range(0, 2) == 0);
      hw_int = 6'($urandom);
      exc_req = ($urandom_range(0, 6) == 0);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      exc_bd = 1'($urandom_range(0, 1));
      eret = ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (epc_out !== m_epc) begin errors++; $display("FAIL rnd_epc_out i=%0d got %h exp %h", i, epc_out, m_epc); end

      // Reference: apply this cycle's events to the architectural registers
      wr = wEn && (sel == 3'd0);
      old_exl = m_status[1];
      n_count = m_phase ? m_count + 1 : m_count;
      if (wr && r == 5'd9) n_count = din;
      if (n_count == m_compare) m_ti = 1;
      if (wr && r == 5'd11) begin m_compare = din; m_ti = 0; end
      m_count = n_count;
      m_phase = !m_phase;
      m_hwip = hw_int;
      if (wr && r == 5'd12) m_status = (m_status & ~WMASK) | (din & WMASK);
      if (wr && r == 5'd13) m_swip = din[9:8];
      if (wr && r == 5'd14) m_epc = din;
      if (eret) m_status[1] = 0;
      if (exc_req) begin
        m_status[1] = 1;
        m_exc = exc_code;
        if (!old_exl) begin m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc; m_bd = exc_bd; end
      end
      m_ip = {m_hwip[5] | m_ti, m_hwip[4:0], m_swip};

      clk_step();
      rd(5'd9, 3'd0, v);
      checks++; if (v !== m_count) begin errors++; $display("FAIL rnd_count i=%0d got %h exp %h", i, v, m_count); end
      rd(5'd11, 3'd0, v);
      checks++; if (v !== m_compare) begin errors++; $display("FAIL rnd_compare i=%0d got %h exp %h", i, v, m_compare); end
      rd(5'd12, 3'd0, v);
      checks++; if (v !== m_status) begin errors++; $display("FAIL rnd_status i=%0d got %h exp %h", i, v, m_status); end
      rd(5'd13, 3'd0, v);
      checks++; if (v !== {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00}) begin errors++; $display("FAIL rnd_cause i=%0d got %h exp %h", i, v, {m_bd, m_ti, 14'd0, m_ip, 1'b0, m_exc, 2'b00}); end
      rd(5'd14, 3'd0, v);
      checks++; if (v !== m_epc) begin errors++; $display("FAIL rnd_epc i=%0d got %h exp %h", i, v, m_epc); end
      checks++; if (in_handler !== m_status[1]) begin errors++; $display("FAIL rnd_in_handler i=%0d got %b exp %b", i, in_handler, m_status[1]); end
      checks++; if (irq !== (m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 0))) begin errors++; $display("FAIL rnd_irq i=%0d got %b exp %b", i, irq, (m_status[0] && !m_status[1] && ((m_ip & m_status[15:8]) != 0))); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_hwint_exc();
    test_nested_bd();
    test_timer();
    test_eret();
    test_reads();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
